bitonic_sort_pipe: RTL and testbench
====================================

// Module: bitonic_sort_pipe
// PURPOSE
//  Fully pipelined bitonic sorting network: one DEPTH-element vector accepted per cycle, sorted
//  by registered compare-and-swap (CAS) stages, emitted with original-position tags. Successor to
//  the recursive combinational sorter; adds real CAS network, per-vector direction, signed keys,
//  valid/ready backpressure. Sits between the packet-field extractor and the top-K selector.
// PARAMETERS
//  DEPTH   8   elements per vector; power of 2, >=2 (else elaboration $error)
//  WIDTH   32  bits per element (key)
//  SIGNED  0   1: keys compared as two's complement; 0: unsigned
//  LOGD    $clog2(DEPTH)  localparam; STAGES = LOGD*(LOGD+1)/2 (DEPTH=8 -> 6)
// PORTS
//  clk         in   1               clock, all state on rising edge
//  rst         in   1               synchronous reset, active-high
//  valid_in    in   1               input vector valid
//  ready_out   out  1               block can accept (to upstream)
//  descend_in  in   1               1: sort descending, 0: ascending; travels with vector
//  seq_in      in   WIDTH x DEPTH   unpacked array [0:DEPTH-1], element 0 first
//  seq_out     out  WIDTH x DEPTH   sorted vector [0:DEPTH-1]
//  idx_out     out  LOGD x DEPTH    idx_out[k] = seq_in position of seq_out[k]
//  valid_out   out  1               output vector valid
//  ready_in    in   1               downstream accepts (from downstream)
// BEHAVIOUR
//  - Pipeline: STAGES register stages, each = one CAS layer of standard bitonic network
//    (merge size 2^p, p=1..LOGD; distance 2^q, q=p-1..0). Each stage reg holds data, idx,
//    descend bit, valid bit. Idx initialised 0..DEPTH-1 at stage-0 entry.
//  - CAS direction for pair (i, i+d) in merge block of size 2^p: ascending if
//    ((i >> p) & 1) == 0, XOR descend bit of that vector; final merge (p=LOGD) is whole vector.
//  - Compare strictly: swap only if lo>hi (asc) / lo<hi (desc); equal keys never swap; idx swaps
//    with data. Sign per SIGNED; no width extension, no arithmetic beyond compare.
//  - Handshake: stall = valid_out & ~ready_in. ready_out = ~stall (combinational).
//    Transfer in when valid_in & ready_out; out when valid_out & ready_in.
//  - On stall all stages hold (data, idx, valid); no bubble compression. Not stalled: every
//    stage advances, stage 0 loads valid_in (bubble if low), seq_in ignored when valid_in=0.
//  - Latency: STAGES cycles unstalled; accepted at edge n -> valid_out high after edge n+STAGES-1
//    (DEPTH=8: vector in at cycle 0 visible at out in cycle 6). Throughput 1 vector/cycle.
//  - seq_out/idx_out/valid_out driven directly from last stage register, stable while stalled.
//  - Reset: all valid bits 0, all data/idx regs 0; seq_out=0, idx_out=0, valid_out=0,
//    ready_out=1 on first cycle after reset. Reset mid-flight discards every in-flight vector;
//    no partial output. Reset wins over simultaneous valid_in.
//  - valid_in held with ready_out=0: upstream must hold seq_in/descend_in stable (AXI-style).
//  - Invalid-stage data contents don't care internally but must not reach seq_out as valid.
// TESTING
//  1 DEPTH=8 WIDTH=8 asc: seq_in {5,3,7,1,0,6,2,4} -> seq_out {0,1,2,3,4,5,6,7},
//    idx_out {4,3,6,1,7,0,5,2}, valid_out 1 cycle exactly 6 cycles after accept.
//  2 Same input, descend_in=1 -> seq_out {7,6,5,4,3,2,1,0}, idx_out {2,5,0,7,1,6,3,4}.
//  3 SIGNED=1: {8'hFF,8'h01,8'h80,8'h7F,0,0,8'hFE,8'h02} asc -> {80,FE,FF,00,00,01,02,7F};
//    duplicate zeros keep idx order {4,5}.
//  4 Back-to-back 20 random vectors, random descend, ready_in=1 -> 20 outputs, in order,
//    consecutive cycles, each matches reference model sort (with tie-preserving idx rule).
//  5 ready_in low 3 cycles while valid_out=1 -> seq_out/idx_out frozen, ready_out=0,
//    no vector lost or duplicated after ready_in returns.
//  6 rst pulsed with 4 vectors in flight -> valid_out=0 next cycle, outputs 0, ready_out=1,
//    nothing emitted until a new vector is accepted + 6 cycles.

Source files
------------

// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe: fully pipelined bitonic sorting network.
// Accepts one DEPTH-element vector per cycle and sorts it through STAGES registered
// compare-and-swap layers. Each output element carries a tag giving its original
// position in the input vector. Sort direction is chosen per vector and travels
// with it down the pipe.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   valid_in     input vector valid;  ready_out  block can accept (combinational)
//   descend_in   1: descending, 0: ascending (per vector)
//   seq_in       input keys, element 0 first
//   seq_out      sorted keys;  idx_out  input position of each sorted key
//   valid_out    output vector valid;  ready_in  downstream accepts
module bitonic_sort_pipe #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic                     descend_in,
    input  logic [WIDTH-1:0]         seq_in  [0:DEPTH-1],
    output logic [WIDTH-1:0]         seq_out [0:DEPTH-1],
    output logic [$clog2(DEPTH)-1:0] idx_out [0:DEPTH-1],
    output logic                     valid_out,
    input  logic                     ready_in
);

    localparam int unsigned LOGD   = $clog2(DEPTH);
    localparam int unsigned STAGES = LOGD * (LOGD + 1) / 2;
    // The last stage's direction bit is never consumed, so only STAGES-1 are kept.
    localparam int unsigned DREGS  = (STAGES > 1) ? STAGES - 1 : 1;

    typedef logic [DEPTH-1:0][WIDTH-1:0] vec_t;
    typedef logic [DEPTH-1:0][LOGD-1:0]  tag_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bitonic_sort_pipe: DEPTH must be a power of 2 and >= 2");
    end

    // Pipeline registers
    vec_t              st_data [STAGES];
    tag_t              st_idx  [STAGES];
    logic [STAGES-1:0] st_vld;
    logic [DREGS-1:0]  st_desc;

    // Per-layer CAS inputs and outputs
    vec_t              cas_in_data  [STAGES];
    tag_t              cas_in_idx   [STAGES];
    logic [STAGES-1:0] cas_in_desc;
    vec_t              cas_out_data [STAGES];
    tag_t              cas_out_idx  [STAGES];

    logic stall;

    // Key comparison: strict less-than, signedness per parameter
    function automatic logic key_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    // Layer 0 takes the input vector and seeds position tags 0..DEPTH-1
    for (genvar k = 0; k < DEPTH; k++) begin : g_in
        assign cas_in_data[0][k] = seq_in[k];
        assign cas_in_idx[0][k]  = LOGD'(k);
    end
    assign cas_in_desc[0] = descend_in;

    // Later layers read the previous stage register
    for (genvar s = 1; s < STAGES; s++) begin : g_link
        assign cas_in_data[s] = st_data[s-1];
        assign cas_in_idx[s]  = st_idx[s-1];
        assign cas_in_desc[s] = st_desc[s-1];
    end

    // CAS layers: merge size 2^p, distance 2^(p-1-r); layer number S counts across merges
    for (genvar p = 1; p <= LOGD; p++) begin : g_merge
        for (genvar r = 0; r < p; r++) begin : g_layer
            localparam int unsigned S = p * (p - 1) / 2 + r;
            localparam int unsigned D = 1 << (p - 1 - r);
            for (genvar i = 0; i < DEPTH; i++) begin : g_pair
                if ((i & D) == 0) begin : g_cas
                    localparam int unsigned J  = i + D;
                    // Block direction before applying the per-vector flip
                    localparam bit          UP = ((i >> p) & 1) == 0;
                    logic asc;
                    logic swap;
                    assign asc  = UP ^ cas_in_desc[S];
                    // Equal keys never swap
                    assign swap = asc ? key_lt(cas_in_data[S][J], cas_in_data[S][i])
                                      : key_lt(cas_in_data[S][i], cas_in_data[S][J]);
                    assign cas_out_data[S][i] = swap ? cas_in_data[S][J] : cas_in_data[S][i];
                    assign cas_out_data[S][J] = swap ? cas_in_data[S][i] : cas_in_data[S][J];
                    assign cas_out_idx[S][i]  = swap ? cas_in_idx[S][J]  : cas_in_idx[S][i];
                    assign cas_out_idx[S][J]  = swap ? cas_in_idx[S][i]  : cas_in_idx[S][J];
                end
            end
        end
    end

    // Whole pipe freezes while the output is held by downstream
    assign stall     = st_vld[STAGES-1] & ~ready_in;
    assign ready_out = ~stall;

    // Stage registers: hold on stall, otherwise every stage advances
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                st_data[s] <= '0;
                st_idx[s]  <= '0;
            end
            st_vld  <= '0;
            st_desc <= '0;
        end else if (!stall) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                st_data[s] <= cas_out_data[s];
                st_idx[s]  <= cas_out_idx[s];
            end
            st_vld[0] <= valid_in;
            for (int unsigned s = 1; s < STAGES; s++) begin
                st_vld[s] <= st_vld[s-1];
            end
            for (int unsigned s = 0; s < DREGS; s++) begin
                st_desc[s] <= cas_in_desc[s];
            end
        end
    end

    // Outputs straight from the last stage register
    for (genvar k = 0; k < DEPTH; k++) begin : g_out
        assign seq_out[k] = st_data[STAGES-1][k];
        assign idx_out[k] = st_idx[STAGES-1][k];
    end
    assign valid_out = st_vld[STAGES-1];

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Testbench for bitonic_sort_pipe: table-driven known vectors, random back-to-back
// stream, output stall, and reset with vectors in flight. Expected results come from
// a stable insertion-sort reference and are queued at accept, compared at output.
module tb_bitonic_sort_pipe;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned LOGD   = 3;
    localparam int unsigned STAGES = 6;

    typedef logic [DEPTH-1:0][WIDTH-1:0] vec_t;
    typedef logic [DEPTH-1:0][LOGD-1:0]  tag_t;
    typedef struct packed { vec_t data; tag_t idx; } exp_t;
    typedef struct {
        vec_t vin;
        logic desc;
        logic sgn;
        vec_t dexp;
        tag_t iexp;
    } vec_rec_t;

    logic             clk;
    logic             rst;
    logic             valid_in, ready_out, descend_in, valid_out, ready_in;
    logic [WIDTH-1:0] seq_in  [0:DEPTH-1];
    logic [WIDTH-1:0] seq_out [0:DEPTH-1];
    logic [LOGD-1:0]  idx_out [0:DEPTH-1];

    logic             valid_in_s, ready_out_s, descend_in_s, valid_out_s, ready_in_s;
    logic [WIDTH-1:0] seq_in_s  [0:DEPTH-1];
    logic [WIDTH-1:0] seq_out_s [0:DEPTH-1];
    logic [LOGD-1:0]  idx_out_s [0:DEPTH-1];

    bitonic_sort_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .descend_in(descend_in), .seq_in(seq_in), .seq_out(seq_out), .idx_out(idx_out),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    bitonic_sort_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .valid_in(valid_in_s), .ready_out(ready_out_s),
        .descend_in(descend_in_s), .seq_in(seq_in_s), .seq_out(seq_out_s), .idx_out(idx_out_s),
        .valid_out(valid_out_s), .ready_in(ready_in_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       checks;
    int       errors;
    int       cycle;
    int       n_recv;
    int       first_out_cycle;
    int       last_out_cycle;
    logic     accepted;
    exp_t     next_exp;
    exp_t     sb [$];
    vec_rec_t tbl [3];

    function automatic vec_t mkv(input int unsigned a [DEPTH]);
        vec_t v;
        for (int k = 0; k < DEPTH; k++) v[k] = WIDTH'(a[k]);
        return v;
    endfunction

    function automatic tag_t mkt(input int unsigned a [DEPTH]);
        tag_t t;
        for (int k = 0; k < DEPTH; k++) t[k] = LOGD'(a[k]);
        return t;
    endfunction

    function automatic vec_t pack_vec(input logic [WIDTH-1:0] a [DEPTH]);
        vec_t v;
        for (int k = 0; k < DEPTH; k++) v[k] = a[k];
        return v;
    endfunction

    function automatic tag_t pack_tag(input logic [LOGD-1:0] a [DEPTH]);
        tag_t t;
        for (int k = 0; k < DEPTH; k++) t[k] = a[k];
        return t;
    endfunction

    // Stable insertion sort of unsigned keys; ties keep input order
    function automatic exp_t ref_sort(input vec_t v, input logic desc);
        logic [WIDTH-1:0] d [DEPTH];
        logic [LOGD-1:0]  t [DEPTH];
        exp_t             e;
        int               j;
        for (int k = 0; k < DEPTH; k++) begin
            j = k;
            while (j > 0 && (desc ? (v[k] > d[j-1]) : (v[k] < d[j-1]))) begin
                d[j] = d[j-1];
                t[j] = t[j-1];
                j--;
            end
            d[j] = v[k];
            t[j] = LOGD'(k);
        end
        for (int k = 0; k < DEPTH; k++) begin
            e.data[k] = d[k];
            e.idx[k]  = t[k];
        end
        return e;
    endfunction

    function automatic vec_t rand_distinct();
        vec_t v;
        logic dup;
        for (int k = 0; k < DEPTH; k++) begin
            do begin
                v[k] = WIDTH'($urandom_range(0, 255));
                dup  = 1'b0;
                for (int j = 0; j < k; j++) if (v[j] == v[k]) dup = 1'b1;
            end while (dup);
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cycle);
        end
    endtask

    task automatic drive(input vec_t v, input logic d);
        for (int k = 0; k < DEPTH; k++) seq_in[k] = v[k];
        descend_in = d;
    endtask

    // One clock: score output and queue accepted input before the edge, then advance
    task automatic tick();
        exp_t e;
        #1;
        accepted = 1'b0;
        if (!rst) begin
            if (valid_out && ready_in) begin
                n_recv++;
                if (n_recv == 1) first_out_cycle = cycle;
                last_out_cycle = cycle;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %h with empty scoreboard (cycle %0d)",
                             pack_vec(seq_out), cycle);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", 64'(pack_vec(seq_out)), 64'(e.data));
                    chk("sb_idx", 64'(pack_tag(idx_out)), 64'(e.idx));
                end
            end
            accepted = valid_in && ready_out;
            if (accepted) sb.push_back(next_exp);
        end
        @(posedge clk);
        #1;
        cycle++;
        if (cycle > 20000) begin
            $display("FAIL cycle_budget: got %0d cycles required below 20000", cycle);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic drain(input int budget);
        int g;
        g = 0;
        while (sb.size() > 0 && g < budget) begin
            tick();
            g++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        vec_t v;
        logic d;
        int   sent;
        int   stall_left;
        logic stall_done;
        vec_t snap_d;
        tag_t snap_i;
        int   k;

        checks = 0; errors = 0; cycle = 0; n_recv = 0;
        first_out_cycle = 0; last_out_cycle = 0; accepted = 1'b0;
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1; descend_in = 1'b0;
        valid_in_s = 1'b0; ready_in_s = 1'b1; descend_in_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            seq_in[i] = '0;
            seq_in_s[i] = '0;
        end
        next_exp = '0;

        tbl[0].vin  = mkv('{5, 3, 7, 1, 0, 6, 2, 4});
        tbl[0].desc = 1'b0; tbl[0].sgn = 1'b0;
        tbl[0].dexp = mkv('{0, 1, 2, 3, 4, 5, 6, 7});
        tbl[0].iexp = mkt('{4, 3, 6, 1, 7, 0, 5, 2});
        tbl[1].vin  = mkv('{5, 3, 7, 1, 0, 6, 2, 4});
        tbl[1].desc = 1'b1; tbl[1].sgn = 1'b0;
        tbl[1].dexp = mkv('{7, 6, 5, 4, 3, 2, 1, 0});
        tbl[1].iexp = mkt('{2, 5, 0, 7, 1, 6, 3, 4});
        tbl[2].vin  = mkv('{'hFF, 'h01, 'h80, 'h7F, 0, 0, 'hFE, 'h02});
        tbl[2].desc = 1'b0; tbl[2].sgn = 1'b1;
        tbl[2].dexp = mkv('{'h80, 'hFE, 'hFF, 0, 0, 'h01, 'h02, 'h7F});
        tbl[2].iexp = mkt('{2, 6, 0, 4, 5, 1, 7, 3});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_ready_out", 64'(ready_out), 64'd1);
        chk("rst_seq_out", 64'(pack_vec(seq_out)), 64'd0);
        chk("rst_idx_out", 64'(pack_tag(idx_out)), 64'd0);
        rst = 1'b0;

        // Known vectors with exact latency and single-cycle valid
        for (int t = 0; t < 3; t++) begin
            if (!tbl[t].sgn) begin
                drive(tbl[t].vin, tbl[t].desc);
                valid_in = 1'b1;
                next_exp.data = tbl[t].dexp;
                next_exp.idx  = tbl[t].iexp;
                tick();
                chk("tbl_accept", 64'(accepted), 64'd1);
                valid_in = 1'b0;
                for (int c = 1; c < STAGES; c++) begin
                    chk("tbl_latency_low", 64'(valid_out), 64'd0);
                    tick();
                end
                chk("tbl_latency_high", 64'(valid_out), 64'd1);
                tick();
                chk("tbl_one_cycle", 64'(valid_out), 64'd0);
                chk("tbl_sb_empty", 64'(sb.size()), 64'd0);
            end else begin
                for (int i = 0; i < DEPTH; i++) seq_in_s[i] = tbl[t].vin[i];
                descend_in_s = tbl[t].desc;
                valid_in_s = 1'b1;
                tick();
                valid_in_s = 1'b0;
                k = 1;
                while (!valid_out_s && k < 12) begin
                    tick();
                    k++;
                end
                chk("signed_latency", 64'(k), 64'(STAGES));
                chk("signed_data", 64'(pack_vec(seq_out_s)), 64'(tbl[t].dexp));
                chk("signed_idx", 64'(pack_tag(idx_out_s)), 64'(tbl[t].iexp));
            end
        end

        // 20 random vectors back to back, random direction
        n_recv = 0;
        for (int n = 0; n < 20; n++) begin
            v = rand_distinct();
            d = 1'($urandom_range(0, 1));
            drive(v, d);
            valid_in = 1'b1;
            next_exp = ref_sort(v, d);
            tick();
            chk("b2b_accept", 64'(accepted), 64'd1);
        end
        valid_in = 1'b0;
        drain(40);
        chk("b2b_count", 64'(n_recv), 64'd20);
        chk("b2b_consecutive", 64'(last_out_cycle - first_out_cycle), 64'd19);

        // Stream with a 3-cycle downstream stall while output is valid
        n_recv = 0; sent = 0; stall_left = 0; stall_done = 1'b0;
        snap_d = '0; snap_i = '0;
        v = rand_distinct();
        d = 1'($urandom_range(0, 1));
        k = 0;
        while ((sent < 10 || sb.size() > 0) && k < 200) begin
            if (sent < 10) begin
                drive(v, d);
                valid_in = 1'b1;
                next_exp = ref_sort(v, d);
            end else begin
                valid_in = 1'b0;
            end
            if (!stall_done && stall_left == 0 && valid_out) begin
                stall_left = 3;
                snap_d = pack_vec(seq_out);
                snap_i = pack_tag(idx_out);
            end
            ready_in = (stall_left == 0);
            tick();
            if (stall_left > 0) begin
                chk("stall_seq_frozen", 64'(pack_vec(seq_out)), 64'(snap_d));
                chk("stall_idx_frozen", 64'(pack_tag(idx_out)), 64'(snap_i));
                chk("stall_ready_out", 64'(ready_out), 64'd0);
                chk("stall_valid_out", 64'(valid_out), 64'd1);
                stall_left--;
                if (stall_left == 0) stall_done = 1'b1;
            end
            if (accepted) begin
                sent++;
                v = rand_distinct();
                d = 1'($urandom_range(0, 1));
            end
            k++;
        end
        ready_in = 1'b1;
        valid_in = 1'b0;
        chk("stall_happened", 64'(stall_done), 64'd1);
        chk("stall_count", 64'(n_recv), 64'd10);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with four vectors in flight, valid_in high during reset
        for (int n = 0; n < 4; n++) begin
            v = rand_distinct();
            drive(v, 1'b0);
            valid_in = 1'b1;
            next_exp = ref_sort(v, 1'b0);
            tick();
        end
        chk("inflight_before_rst", 64'(sb.size()), 64'd4);
        v = rand_distinct();
        drive(v, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid_in = 1'b0;
        sb.delete();
        chk("rst6_valid_out", 64'(valid_out), 64'd0);
        chk("rst6_seq_out", 64'(pack_vec(seq_out)), 64'd0);
        chk("rst6_idx_out", 64'(pack_tag(idx_out)), 64'd0);
        chk("rst6_ready_out", 64'(ready_out), 64'd1);
        n_recv = 0;
        repeat (10) tick();
        chk("rst6_no_emit", 64'(n_recv), 64'd0);
        v = rand_distinct();
        drive(v, 1'b1);
        valid_in = 1'b1;
        next_exp = ref_sort(v, 1'b1);
        tick();
        valid_in = 1'b0;
        k = 1;
        while (!valid_out && k < 12) begin
            tick();
            k++;
        end
        chk("rst6_new_latency", 64'(k), 64'(STAGES));
        drain(4);
        chk("rst6_recv", 64'(n_recv), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
